// File: rtl/oled_stream_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// oled_stream_pkg : FSM encoding and constants shared by the OLED streamer
// Rev 1.0
// ---------------------------------------------------------------------------
package oled_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_WAIT_RDY = 3'd2,
    ST_SEND     = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam logic [7:0] ASCII_SPACE        = 8'h20;
  localparam int         DEFAULT_STRING_LEN = 64;

endpackage
`default_nettype wire

// File: rtl/oled_msg_streamer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// oled_msg_streamer_if : byte handshake towards oledControl
// Rev 1.0
// ---------------------------------------------------------------------------
interface oled_msg_streamer_if;

  logic [7:0] send_data;
  logic       send_data_valid;
  logic       send_done;

  modport master (output send_data, output send_data_valid, input send_done);
  modport slave  (input send_data, input send_data_valid, output send_done);

endinterface
`default_nettype wire

// File: rtl/refresh_tick_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// refresh_tick_gen : free-running 0..PERIOD-1 counter, tick on the last count
// Rev 1.0
// ---------------------------------------------------------------------------
module refresh_tick_gen #(
  parameter int PERIOD = 500000
) (
  input  logic CLK100MHZ,
  input  logic reset,
  output logic tick
);

  localparam int            CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] count;

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule
`default_nettype wire

// File: rtl/oled_msg_streamer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// oled_msg_streamer : snapshots a flat ASCII message and streams it bytewise
// Rev 1.0
// ---------------------------------------------------------------------------
module oled_msg_streamer
  import oled_stream_pkg::*;
#(
  parameter int STRING_LEN     = DEFAULT_STRING_LEN,
  parameter int REFRESH_CYCLES = 500000,
  parameter int SEL_W          = 4,
  parameter bit CHANGE_REFRESH = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic                    CLK100MHZ,
  input  logic                    reset,
  input  logic [8*STRING_LEN-1:0] message,
  input  logic [SEL_W-1:0]        sel,
  oled_msg_streamer_if.master     oled,
  output logic                    update_string,
  output logic                    busy,
  output logic                    frame_done,
  output logic [CNT_W-1:0]        frame_count
);

  localparam int               IDX_W    = $clog2(STRING_LEN + 1);
  localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(STRING_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(1);

  state_t                  state;
  state_t                  state_nxt;
  logic [8*STRING_LEN-1:0] snap;
  logic [IDX_W-1:0]        idx;
  logic [SEL_W-1:0]        sel_q;
  logic                    tick;
  logic                    chg;
  logic                    pend;
  logic [7:0]              cur_byte;

  refresh_tick_gen #(.PERIOD(REFRESH_CYCLES)) u_tick (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .tick      (tick)
  );

  assign chg = CHANGE_REFRESH && (sel != sel_q);

  // Requests merge into one flag; a new request wins over the LOAD-entry clear.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      pend  <= 1'b1;
      sel_q <= sel;
    end else begin
      sel_q <= sel;
      if (tick || chg) begin
        pend <= 1'b1;
      end else if (state == ST_IDLE && pend) begin
        pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:     if (pend) state_nxt = ST_LOAD;
      ST_LOAD:     state_nxt = ST_WAIT_RDY;
      ST_WAIT_RDY: if (!oled.send_done) state_nxt = ST_SEND;
      ST_SEND:     if (oled.send_done) state_nxt = (idx == IDX_LAST) ? ST_DONE : ST_WAIT_RDY;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // idx counts down from STRING_LEN; byte idx sits at snap[8*idx-1 -: 8].
  always_comb begin
    cur_byte = ASCII_SPACE;
    for (int i = 1; i <= STRING_LEN; i++) begin
      if (idx == IDX_W'(i)) cur_byte = snap[8*i-1 -: 8];
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      snap                 <= {STRING_LEN{ASCII_SPACE}};
      idx                  <= IDX_FULL;
      oled.send_data       <= 8'h00;
      oled.send_data_valid <= 1'b0;
      update_string        <= 1'b0;
      busy                 <= 1'b0;
      frame_done           <= 1'b0;
      frame_count          <= '0;
    end else begin
      update_string <= (state == ST_IDLE) && pend;
      busy          <= (state_nxt != ST_IDLE);
      frame_done    <= (state == ST_DONE);
      case (state)
        ST_LOAD: begin
          snap <= message;
          idx  <= IDX_FULL;
        end
        ST_WAIT_RDY: begin
          if (!oled.send_done) begin
            oled.send_data       <= cur_byte;
            oled.send_data_valid <= 1'b1;
          end
        end
        ST_SEND: begin
          if (oled.send_done) begin
            oled.send_data_valid <= 1'b0;
            idx                  <= idx - 1'b1;
          end
        end
        ST_DONE: frame_count <= frame_count + 1'b1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/oled_msg_streamer.md
# oled_msg_streamer

Parametrised byte streamer between the direction-classification logic and `oledControl`. It snapshots a flat ASCII message bus at the start of each frame, then delivers it byte by byte over the `sendData`/`sendDataValid`/`sendDone` handshake. Frames start on a programmable refresh period and, optionally, immediately when the message-select code changes. Because the message is snapshotted, a frame never contains a mix of old and new text.

## Interface
- `STRING_LEN`, 64: bytes per frame; ≥1.
- `REFRESH_CYCLES`, 500000: clock cycles between periodic refresh ticks; ≥2.
- `SEL_W`, 4: width of the message-select code.
- `CHANGE_REFRESH`, 1: 1 means a change of `sel` requests a frame; 0 means periodic refresh only.
- `CNT_W`, 16: width of `frame_count`.

Ports:
- `CLK100MHZ`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `message`  in  8*STRING_LEN  ASCII text; bits [8*STRING_LEN-1 -: 8] hold the first character.
- `sel`  in  SEL_W  message-select code (the direction code).
- `send_data`  out  8  byte presented to `oledControl`.
- `send_data_valid`  out  1  byte valid.
- `send_done`  in  1  `oledControl` byte-accepted/ready flag.
- `update_string`  out  1  one-cycle pulse at frame start.
- `busy`  out  1  high from LOAD through DONE.
- `frame_done`  out  1  one-cycle pulse after the last byte.
- `frame_count`  out  CNT_W  completed frames; wraps modulo 2^CNT_W.

## Operation
- **Refresh counter.**
  - Counts 0..REFRESH_CYCLES-1, then wraps.
  - `tick` is asserted when the count equals REFRESH_CYCLES-1.
- **Change detect.** `sel_q` registers `sel`. `chg = CHANGE_REFRESH && (sel != sel_q)`.
- **Request flag `pend`.**
  - Set by `tick` or `chg`.
  - Cleared on entry to LOAD.
  - Requests that arrive while already pending or busy merge into the single flag. There is no queue depth beyond 1.
  - If a set and a clear happen in the same cycle, the set wins.
- **FSM states.**
  - IDLE: go to LOAD when `pend`.
  - LOAD:
    - Latch `message` into `snap`.
    - Set `idx = STRING_LEN`.
    - Pulse `update_string`.
    - Go to WAIT_RDY.
  - WAIT_RDY: when `send_done`=0, drive `send_data = snap[8*idx-1 -: 8]` and `send_data_valid`=1, then go to SEND.
  - SEND: when `send_done`=1:
    - Drive `send_data_valid`=0.
    - Decrement `idx`.
    - Go to DONE if `idx`==1, otherwise go to WAIT_RDY.
  - DONE:
    - Pulse `frame_done`.
    - Increment `frame_count`.
    - Go to IDLE.
- **Data stability.** `send_data` holds its value from the WAIT_RDY→SEND transition until the next WAIT_RDY→SEND transition.
- **Input isolation.** Changes to `message` after LOAD have no effect on the frame in flight.
- **Reset.**
  - Applies in any state, including mid-frame.
  - State returns to IDLE and `idx` to STRING_LEN.
  - `pend` is set to 1, so the first frame begins right after reset deasserts.
  - The refresh counter clears to 0 and `sel_q` loads `sel`.
- **Reset values of outputs.** `send_data`=8'h00, `send_data_valid`=0, `update_string`=0, `busy`=0, `frame_done`=0, `frame_count`=0.

## Timing
- Every output is registered.
- **Frame-start latency.**
  - `pend` set → LOAD on the next cycle.
  - `update_string` is high in the cycle after LOAD is entered.
  - The first `send_data_valid` rises no earlier than 2 cycles after `update_string`.
- **Per byte:** at least 2 cycles, plus `oledControl` latency.
- **Handshake rules.**
  - Valid rises only while `send_done`=0.
  - Valid drops in the cycle after `send_done`=1 is sampled in SEND.
  - A `send_done` that is stuck high stalls the block in WAIT_RDY. This is legal, not an error.
- **Frame end.** `frame_done` is asserted exactly 1 cycle after the final valid drop; `busy` falls in the same cycle.
- **STRING_LEN=1:** the sequence is LOAD→WAIT_RDY→SEND→DONE.
- **Back-to-back frames.** A `tick` arriving during a frame produces the next LOAD 2 cycles after DONE (DONE→IDLE→LOAD).

## Structure
- **Shared package `oled_stream_pkg`:**
  - state encoding `ST_IDLE`, `ST_LOAD`, `ST_WAIT_RDY`, `ST_SEND`, `ST_DONE` (3 bits);
  - the `ASCII_SPACE` constant;
  - the default `STRING_LEN`.
- **Sub-module `refresh_tick_gen`:** parameter `PERIOD`; ports `CLK100MHZ`, `reset`, `tick`. It implements the refresh counter.
- The FSM, snapshot register, and change detect live in the top of the block.

## Test plan
Parameters for all scenarios: STRING_LEN=4, REFRESH_CYCLES=100. The `oledControl` model asserts `send_done` 3 cycles after valid and deasserts it 1 cycle after valid drops.
1. **Reset then idle.** Release reset with `message`="UP  " → `update_string` pulse, then bytes 0x55, 0x50, 0x20, 0x20 in order, then `frame_done`, then `frame_count`=1.
2. **Periodic refresh.** Hold `sel`, run 350 cycles → `frame_count`=4 (post-reset frame plus 3 ticks) and exactly 4 `update_string` pulses.
3. **Change refresh.** Flip `sel` 4'b0001→4'b0010 at cycle 20 with CHANGE_REFRESH=1 → LOAD within 2 cycles. With CHANGE_REFRESH=0 → no frame until the tick.
4. **Snapshot integrity.** Change `message` "DOWN"→"LEFT" after the first byte → the frame sends "DOWN". The next frame sends "LEFT".
5. **Merged requests.** Fire `tick` and 3 `sel` changes during one frame → exactly one further frame follows.
6. **Mid-frame reset.** Assert reset after byte 2 → `send_data_valid`=0 next cycle, `frame_count`=0, and a full 4-byte frame restarts after release.
